// File: rtl/if_fetch_ctrl_if.sv
// Instruction bus (SRAM-like) between the fetch sequencer and the instruction memory.
interface if_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata1;
    logic [31:0] inst_rdata2;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2
    );
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one bus fetch per PC, stale-response drop, PC advance strobes.
// Build option IF_FETCH_DUAL_EN enables two-word delivery (PC advance by 8).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_curr,
    input  logic                  redirect,
    input  logic                  occupy,
    input  logic [1:0]            iq_space,
    if_fetch_ctrl_if.master       bus,
    output logic                  inst_data_ok1,
    output logic                  inst_data_ok2,
    output logic                  iq_push1,
    output logic                  iq_push2,
    output logic [31:0]           iq_inst1,
    output logic [31:0]           iq_inst2,
    output logic [31:0]           iq_pc1,
    output logic [31:0]           iq_pc2,
    output logic                  iq_adel1
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic        drop_pend;
    logic        can_fetch;
    logic        pc_aligned;

    assign can_fetch  = !occupy && !redirect && (iq_space != 2'd0);
    assign pc_aligned = (pc_curr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            drop_pend <= 1'b0;
        end else begin
            if (state == IDLE && can_fetch && pc_aligned) fetch_pc <= pc_curr;
            // A redirect while the address is still pending makes the eventual response stale.
            if (state == ADDR) begin
                if (bus.inst_addr_ok) drop_pend <= 1'b0;
                else if (redirect)    drop_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (can_fetch && pc_aligned) state_nxt = ADDR;
            ADDR: if (bus.inst_addr_ok) state_nxt = (redirect || drop_pend) ? DROP : DATA;
            DATA: begin
                if (bus.inst_data_ok) state_nxt = IDLE;
                else if (redirect)    state_nxt = DROP;
            end
            DROP: if (bus.inst_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.inst_req  = 1'b0;
        bus.inst_addr = fetch_pc;
        inst_data_ok1 = 1'b0;
        inst_data_ok2 = 1'b0;
        iq_push1      = 1'b0;
        iq_push2      = 1'b0;
        iq_inst1      = 32'd0;
        iq_inst2      = 32'd0;
        iq_pc1        = 32'd0;
        iq_pc2        = 32'd0;
        iq_adel1      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // Misaligned PC: report an address error without touching the bus.
                    if (can_fetch && !pc_aligned) begin
                        inst_data_ok1 = 1'b1;
                        iq_push1      = 1'b1;
                        iq_pc1        = pc_curr;
                        iq_adel1      = 1'b1;
                    end
                end
                ADDR: bus.inst_req = 1'b1;
                DATA: begin
                    if (bus.inst_data_ok && !redirect) begin
                        inst_data_ok1 = (iq_space != 2'd0);
                        iq_push1      = inst_data_ok1;
                        iq_inst1      = bus.inst_rdata1;
                        iq_pc1        = fetch_pc;
`ifdef IF_FETCH_DUAL_EN
                        inst_data_ok2 = inst_data_ok1 && !fetch_pc[2] && (iq_space == 2'd2);
                        iq_push2      = inst_data_ok2;
                        iq_inst2      = bus.inst_rdata2;
                        iq_pc2        = fetch_pc + 32'd4;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef IF_FETCH_DUAL_EN
    logic unused_rdata2;
    assign unused_rdata2 = ^bus.inst_rdata2;
`endif
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the PC register and the SRAM-like instruction bus. It issues one fetch per PC value and tracks the outstanding transaction. It discards responses made stale by a pipeline redirect, and generates the `inst_data_ok1`/`inst_data_ok2` advance strobes that move the PC by 0, 4 or 8. Fetched words go to the instruction queue feeding dual-issue decode.

## Interface
- `RESET_PC`, 32'hbfc00000, reset value of the latched fetch address.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc_curr`  in  32  current PC from the PC register.
- `redirect`  in  1  exception, taken branch or flush-all this cycle; the PC register loads the target itself.
- `occupy`  in  1  frontend hold; no new request is issued.
- `iq_space`  in  2  free instruction-queue slots, saturating at 2.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  32  bus address, word-aligned.
- `inst_addr_ok`  in  1  address accepted.
- `inst_data_ok`  in  1  read data returned.
- `inst_rdata1`, `inst_rdata2`  in  32 each  words at `inst_addr` and `inst_addr+4`.
- `inst_data_ok1`, `inst_data_ok2`  out  1 each  advance strobes to the PC register.
- `iq_push1`, `iq_push2`  out  1 each  queue write enables.
- `iq_inst1`, `iq_inst2`, `iq_pc1`, `iq_pc2`  out  32 each  queue write data.
- `iq_adel1`  out  1  fetch address-error flag for slot 1.

## Operation
- **States:** IDLE, ADDR, DATA, DROP. Registers: `fetch_pc` (32 bits) and `drop_pend`.
- **Issue condition:** `can_fetch = !occupy && !redirect && iq_space != 0`.
- **IDLE**
  - If `can_fetch` and `pc_curr[1:0]==0`: latch `fetch_pc <= pc_curr`, go to ADDR.
  - If `can_fetch` and `pc_curr[1:0]!=0`: no bus request. In the same cycle drive `iq_push1=1`, `iq_inst1=0`, `iq_pc1=pc_curr`, `iq_adel1=1`, `inst_data_ok1=1`. Stay in IDLE.
- **ADDR**
  - Outputs: `inst_req=1`, `inst_addr=fetch_pc`. Both are held stable until `inst_addr_ok`; a request is never withdrawn.
  - A `redirect` while in ADDR sets `drop_pend`.
  - On `inst_addr_ok`: go to DROP if `redirect || drop_pend`, otherwise go to DATA.
- **DATA**
  - `redirect` without `inst_data_ok`: go to DROP.
  - On `inst_data_ok` with no redirect, deliver:
    - `ok1 = iq_space>=1`.
    - `ok2 = ok1 && fetch_pc[2]==0 && iq_space==2`.
    - `iq_push` mirrors the ok signals. `iq_pc1=fetch_pc`, `iq_pc2=fetch_pc+4`.
    - Go to IDLE.
  - On `inst_data_ok` together with `redirect`: discard, no strobes, go to IDLE.
- **DROP:** wait for `inst_data_ok`, discard the data, go to IDLE. `redirect` in DROP has no further effect.
- **drop_pend:** cleared on leaving ADDR.
- **Strobe rules:**
  - `inst_data_ok2` is never asserted without `inst_data_ok1`.
  - No strobe or push is asserted in any cycle where `redirect=1`.
- **Reset:**
  - `state=IDLE`, `fetch_pc=RESET_PC`, `drop_pend=0`.
  - All outputs 0 except `inst_addr=RESET_PC`.
  - The bus is reset by the same `rst`, so no stale response arrives after reset, including reset mid-transaction.

## Timing
- Strobes and pushes are combinational in the `inst_data_ok` cycle. The PC register updates at the next edge.
- Best case with a same-cycle `addr_ok`:
  - cycle 0: IDLE decision.
  - cycle 1: `inst_req` with `addr_ok`.
  - cycle 2: `data_ok`, strobes.
  - cycle 3: IDLE with the new `pc_curr`.
  - cycle 4: next request.
  - Peak throughput is one fetch per 3 cycles.
- `pc_curr` only changes on strobes or redirects, so it equals `fetch_pc` whenever data is delivered.
- `iq_space` only grows while a fetch is outstanding (this block is the sole writer), so the issue-time check guarantees at least one slot at delivery.

## Configuration
- `IF_FETCH_DUAL_EN` defined: two-word delivery as above.
- `IF_FETCH_DUAL_EN` undefined: `inst_data_ok2`, `iq_push2` tied 0, and `iq_inst2`/`iq_pc2` tied 0. Every fetch advances the PC by at most 4.

## Test plan
- **Aligned dual fetch:** reset, `iq_space=2`, `addr_ok` and `data_ok` one cycle after request → `inst_addr=bfc00000`; `ok1=ok2=1`; `iq_pc2=bfc00004`; next request at `bfc00008`.
- **Odd-word fetch:** `pc_curr=bfc00004`, `iq_space=2` → only `ok1`, next address `bfc00008`. With `iq_space=1` at `bfc00008` → `ok1` only.
- **Redirect in DATA:** redirect in DATA, `data_ok` 2 cycles later → no strobes or pushes, state IDLE, next request at the redirect target.
- **Redirect during ADDR:** redirect while `inst_addr_ok` held low 3 cycles → `inst_addr` stable, then DROP, response discarded.
- **Misaligned PC:** `pc_curr=bfc00002` → no `inst_req`; `iq_adel1=1`, `iq_pc1=bfc00002`, `ok1=1` in the same cycle.
- **Reset mid-transaction and build option:** `rst` asserted in DATA → IDLE, all outputs cleared next cycle. With `IF_FETCH_DUAL_EN` undefined, rerun the first scenario → `ok2=0`, PC steps by 4.
